// File: rtl/acq_sequencer.sv
// Acquisition run controller: clears the tagger counter, holds a gated operate
// window, then drains in-flight records before reporting completion status.
module acq_sequencer #(
    parameter int CLEAR_CYCLES = 4,
    parameter int DRAIN_CYCLES = 8,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] window_len,
    input  logic [CNT_W-1:0] record_limit,
    input  logic             data_rdy,
    output logic             operate,
    output logic             reset_counter,
    output logic             busy,
    output logic             done,
    output logic [1:0]       stop_reason,
    output logic [CNT_W-1:0] elapsed,
    output logic [CNT_W-1:0] record_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] REASON_NONE   = 2'd0;
    localparam logic [1:0] REASON_USER   = 2'd1;
    localparam logic [1:0] REASON_WINDOW = 2'd2;
    localparam logic [1:0] REASON_LIMIT  = 2'd3;

    localparam int PH_MAX = (CLEAR_CYCLES > DRAIN_CYCLES) ? CLEAR_CYCLES : DRAIN_CYCLES;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam logic [PH_W-1:0] CLEAR_LAST = PH_W'(CLEAR_CYCLES - 1);
    localparam logic [PH_W-1:0] DRAIN_LAST = PH_W'(DRAIN_CYCLES - 1);

    state_t           state;
    state_t           state_next;
    logic [PH_W-1:0]  phase_cnt;
    logic [CNT_W-1:0] win_q;
    logic [CNT_W-1:0] lim_q;

    logic             load;
    logic [1:0]       reason_next;
    logic [CNT_W-1:0] elapsed_inc;
    logic [CNT_W-1:0] rec_inc;
    logic             window_hit;
    logic             limit_hit;

    // Saturating increments; the window compare is done one bit wider so
    // elapsed+1 never wraps back onto a small window_len.
    always_comb begin
        elapsed_inc = (elapsed == '1) ? elapsed : elapsed + CNT_W'(1);
        rec_inc     = (data_rdy && (record_count != '1)) ? record_count + CNT_W'(1) : record_count;
        window_hit  = (win_q != '0) &&
                      (({1'b0, elapsed} + (CNT_W + 1)'(1)) == {1'b0, win_q});
        limit_hit   = (lim_q != '0) && (rec_inc >= lim_q);
    end

    always_comb begin
        state_next  = state;
        reason_next = stop_reason;
        load        = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next  = S_CLEAR;
                    reason_next = REASON_NONE;
                    load        = 1'b1;
                end
            end
            S_CLEAR: begin
                if (stop) begin
                    state_next  = S_DONE;
                    reason_next = REASON_USER;
                end else if (phase_cnt == CLEAR_LAST) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                // User stop outranks limit, which outranks window expiry.
                if (stop) begin
                    state_next  = S_DRAIN;
                    reason_next = REASON_USER;
                end else if (limit_hit) begin
                    state_next  = S_DRAIN;
                    reason_next = REASON_LIMIT;
                end else if (window_hit) begin
                    state_next  = S_DRAIN;
                    reason_next = REASON_WINDOW;
                end
            end
            S_DRAIN: begin
                if (phase_cnt == DRAIN_LAST) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            phase_cnt     <= '0;
            win_q         <= '0;
            lim_q         <= '0;
            operate       <= 1'b0;
            reset_counter <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            stop_reason   <= REASON_NONE;
            elapsed       <= '0;
            record_count  <= '0;
        end else begin
            state       <= state_next;
            stop_reason <= reason_next;

            if ((state_next != state) || !((state == S_CLEAR) || (state == S_DRAIN))) begin
                phase_cnt <= '0;
            end else begin
                phase_cnt <= phase_cnt + PH_W'(1);
            end

            if (load) begin
                win_q        <= window_len;
                lim_q        <= record_limit;
                elapsed      <= '0;
                record_count <= '0;
            end else begin
                if (state == S_RUN) begin
                    elapsed <= elapsed_inc;
                end
                if ((state == S_RUN) || (state == S_DRAIN)) begin
                    record_count <= rec_inc;
                end
            end

            // Outputs are decoded from the next state so they change on the
            // same edge as the state register.
            operate       <= (state_next == S_RUN);
            reset_counter <= (state_next == S_CLEAR);
            busy          <= (state_next != S_IDLE);
            done          <= (state_next == S_DONE);
        end
    end

endmodule
